// File: rtl/lsu_port_arb.sv
// LSU memory-port arbiter: issue queue vs. store drain onto one DCache port.
// Tracks response ownership in order; flush drops issue-queue responses.
package lsu_port_arb_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [2:0]  tag;
  } iq_lsu_pkg_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  tag;
    logic        err;
  } lsu_iq_pkg_t;

endpackage

module lsu_port_arb
  import lsu_port_arb_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int STARVE_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  iq_lsu_pkg_t req0_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  iq_lsu_pkg_t req1_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output iq_lsu_pkg_t mem_req_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  lsu_iq_pkg_t mem_resp_i,
  output logic        resp0_valid_o,
  input  logic        resp0_ready_i,
  output logic        resp1_valid_o,
  input  logic        resp1_ready_i,
  output lsu_iq_pkg_t resp_o
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);
  localparam logic [SW-1:0] STV_MAX  = SW'(STARVE_MAX);

  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [CW-1:0]          r_count;
  logic [SW-1:0]          r_starve;
  logic [OUTSTANDING-1:0] r_own;
  logic [OUTSTANDING-1:0] r_drop;

  logic w_can_grant;
  logic w_v0;
  logic w_v1;
  logic w_starved;
  logic w_sel0;
  logic w_sel1;
  logic w_push;
  logic w_pop;
  logic w_nonempty;
  logic w_hd_own;
  logic w_hd_drop;

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Count is the registered value: a same-cycle pop never frees a slot.
  assign w_can_grant = rst_n && (r_count < CNT_MAX);
  assign w_v0        = req0_valid_i && !flush;
  assign w_v1        = req1_valid_i;
  assign w_starved   = (r_starve == STV_MAX);
  assign w_sel0      = w_v0 && (w_starved || !w_v1);
  assign w_sel1      = w_v1 && !w_sel0;

  assign mem_valid_o  = w_can_grant && (w_sel0 || w_sel1);
  assign mem_req_o    = w_sel0 ? req0_i : req1_i;
  assign req0_ready_o = mem_ready_i && w_can_grant && w_sel0;
  assign req1_ready_o = mem_ready_i && w_can_grant && w_sel1;
  assign w_push       = mem_valid_o && mem_ready_i;

  assign w_nonempty = rst_n && (r_count != '0);
  assign w_hd_own   = r_own[r_head];
  assign w_hd_drop  = r_drop[r_head];
  assign resp_o     = mem_resp_i;

  // Route the in-order response by the head entry's owner and drop flag.
  always_comb begin
    mem_resp_ready_o = 1'b0;
    resp0_valid_o    = 1'b0;
    resp1_valid_o    = 1'b0;
    if (w_nonempty) begin
      if (w_hd_drop) begin
        mem_resp_ready_o = 1'b1;
      end else if (w_hd_own) begin
        resp1_valid_o    = mem_resp_valid_i;
        mem_resp_ready_o = resp1_ready_i;
      end else begin
        resp0_valid_o    = mem_resp_valid_i;
        mem_resp_ready_o = resp0_ready_i;
      end
    end
  end

  assign w_pop = mem_resp_valid_i && mem_resp_ready_o;

  // Owner FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= f_nxt(r_tail);
      if (w_pop)  r_head <= f_nxt(r_head);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Owner/drop storage; flush marks owner-0 slots (stale ones are rewritten on push).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_own  <= '0;
      r_drop <= '0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (flush && !r_own[i]) r_drop[i] <= 1'b1;
      end
      if (w_push) begin
        r_own[r_tail]  <= w_sel1;
        r_drop[r_tail] <= 1'b0;
      end
    end
  end

  // Starvation counter for the issue queue while it loses arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (flush || (w_push && w_sel0)) begin
      r_starve <= '0;
    end else if (req0_valid_i && (r_starve != STV_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: doc/lsu_port_arb.md
LSU_PORT_ARB -- requirements
Module: lsu_port_arb

Interface
REQ-001 Parameter OUTSTANDING, default 4: maximum accepted-but-unanswered memory requests.
REQ-002 Parameter STARVE_MAX, default 8: blocked cycles after which requester 0 gains priority.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  pipeline flush; cancels requester-0 traffic only.
REQ-006 req0_valid_i / req0_ready_o  input / output  1 / 1  issue-queue request handshake (requester 0).
REQ-007 req0_i  input  iq_lsu_pkg_t  issue-queue request payload.
REQ-008 req1_valid_i / req1_ready_o  input / output  1 / 1  commit store-drain request handshake (requester 1).
REQ-009 req1_i  input  iq_lsu_pkg_t  store-drain request payload.
REQ-010 mem_valid_o / mem_ready_i  output / input  1 / 1  DCache request handshake.
REQ-011 mem_req_o  output  iq_lsu_pkg_t  granted payload.
REQ-012 mem_resp_valid_i / mem_resp_ready_o  input / output  1 / 1  DCache in-order response handshake.
REQ-013 mem_resp_i  input  lsu_iq_pkg_t  response payload.
REQ-014 resp0_valid_o / resp0_ready_i, resp1_valid_o / resp1_ready_i  output / input  1 each  per-requester response handshakes.
REQ-015 resp_o  output  lsu_iq_pkg_t  equals mem_resp_i, combinationally.

Function
REQ-016 Block SHALL keep an OUTSTANDING-deep circular owner FIFO: per entry 1-bit owner id plus 1-bit drop flag; head/tail pointers wrap modulo OUTSTANDING; count register ranges 0..OUTSTANDING.
REQ-017 Grant SHALL be possible only when registered count < OUTSTANDING; a same-cycle pop SHALL NOT free a slot for that cycle's grant.
REQ-018 Default priority: requester 1 wins over requester 0 when both valid.
REQ-019 starve_cnt (saturating at STARVE_MAX) SHALL increment each cycle req0_valid_i=1, flush=0 and requester 0 not accepted; cleared on requester-0 acceptance or flush.
REQ-020 When starve_cnt == STARVE_MAX, requester 0 SHALL win over requester 1.
REQ-021 mem_valid_o = grant possible AND selected requester valid (requester 0 masked during flush); mem_req_o = selected payload; zero-cycle latency.
REQ-022 reqN_ready_o = mem_ready_i AND grant possible AND requester N selected; at most one of req0_ready_o/req1_ready_o high per cycle.
REQ-023 On accepted request (mem_valid_o AND mem_ready_i) SHALL push {owner, drop=0} at tail.
REQ-024 Head entry routing when count > 0: drop=1 -> mem_resp_ready_o=1, both respN_valid_o=0; otherwise respOWNER_valid_o = mem_resp_valid_i, mem_resp_ready_o = respOWNER_ready_i.
REQ-025 Pop on mem_resp_valid_i AND mem_resp_ready_o; push and pop in same cycle leave count unchanged.
REQ-026 count == 0: mem_resp_ready_o=0, resp0_valid_o=resp1_valid_o=0.
REQ-027 flush SHALL set drop=1 on every valid owner-0 entry (including one pushed-suppressed this cycle: none, since requester 0 is masked); owner-1 entries and requester-1 grant in the flush cycle proceed normally.
REQ-028 A head entry popped in the flush cycle SHALL be routed per its pre-flush drop flag.

Reset
REQ-029 On rst_n=0: head=tail=count=0, starve_cnt=0, all drop/owner bits 0.
REQ-030 Reset values of outputs: req0_ready_o=req1_ready_o=0, mem_valid_o=0, mem_resp_ready_o=0, resp0_valid_o=resp1_valid_o=0 (requests masked while rst_n=0).
REQ-031 Reset mid-operation SHALL discard all outstanding tracking; responses arriving afterward with count 0 are not accepted.

Verification
REQ-032 Both requesters valid, mem_ready_i=1 -> requester 1 granted 8 consecutive cycles, cycle 9 requester 0 granted, starve_cnt returns to 0.
REQ-033 mem_resp_valid_i=0, 4 requests accepted -> count=4, mem_valid_o=0, both readies 0; one response popped -> next cycle grant resumes.
REQ-034 Requests order R0,R1,R0 then 3 responses -> resp0, resp1, resp0 valid in that order; resp1_ready_i=0 stalls mem_resp_ready_o.
REQ-035 2 owner-0 + 1 owner-1 outstanding, flush pulse -> next two owner-0 responses consumed with mem_resp_ready_o=1 and resp0_valid_o=0; owner-1 response delivered.
REQ-036 Pointer wrap: 10 accept/response pairs with continuous traffic -> correct ordering across head/tail wrap, count never exceeds 4.
REQ-037 rst_n=0 with 3 outstanding -> count=0, all outputs per REQ-030 next cycle.
